// File: rtl/gpr_file_if.sv
// Decode/writeback bus for gpr_file: two read ports, a byte-masked write port
// and the scoreboard reservation port.
interface gpr_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]   read_register_1;
  logic [ADDR_WIDTH-1:0]   read_register_2;
  logic [DATA_WIDTH-1:0]   read_data_1;
  logic [DATA_WIDTH-1:0]   read_data_2;
  logic                    read_busy_1;
  logic                    read_busy_2;
  logic [ADDR_WIDTH-1:0]   write_register;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_byteenable;
  logic                    Regwrite;
  logic                    reserve_valid;
  logic [ADDR_WIDTH-1:0]   reserve_register;
  logic                    reserve_ready;
  logic [ADDR_WIDTH:0]     busy_count;

  modport master (
    output read_register_1, read_register_2,
    input  read_data_1, read_data_2, read_busy_1, read_busy_2,
    output write_register, write_data, write_byteenable, Regwrite,
    output reserve_valid, reserve_register,
    input  reserve_ready, busy_count
  );

  modport slave (
    input  read_register_1, read_register_2,
    output read_data_1, read_data_2, read_busy_1, read_busy_2,
    input  write_register, write_data, write_byteenable, Regwrite,
    input  reserve_valid, reserve_register,
    output reserve_ready, busy_count
  );
endinterface

// File: rtl/gpr_file.sv
// Parametrised MIPS register file with byte-lane writes, optional write-to-read
// bypass and a per-register busy scoreboard for pending multicycle writebacks.
module gpr_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  gpr_file_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [ADDR_WIDTH:0]   busy_count_q;

  logic                  wr_zero, rs_zero;
  logic                  wr_en, res_take, set_ev, clr_ev;
  logic [DATA_WIDTH-1:0] wr_merged;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] d,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int unsigned i = 0; i < NB; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    wr_zero   = ZERO_REG && (bus.write_register == '0);
    rs_zero   = ZERO_REG && (bus.reserve_register == '0);
    wr_en     = bus.Regwrite && !wr_zero;
    wr_merged = merge(regs[bus.write_register], bus.write_data, bus.write_byteenable);

    bus.reserve_ready = !reset && (rs_zero || !busy[bus.reserve_register] ||
                        (bus.Regwrite && bus.write_register == bus.reserve_register));
    res_take = bus.reserve_valid && bus.reserve_ready && !rs_zero && !reset;

    // Count tracks real bit transitions, so a same-register set+clear on a
    // busy register is a no-op for the counter.
    set_ev = res_take && !busy[bus.reserve_register];
    clr_ev = bus.Regwrite && busy[bus.write_register] &&
             !(res_take && bus.reserve_register == bus.write_register);
  end

  always_comb begin
    bus.read_data_1 = regs[bus.read_register_1];
    bus.read_data_2 = regs[bus.read_register_2];
    bus.read_busy_1 = busy[bus.read_register_1];
    bus.read_busy_2 = busy[bus.read_register_2];
    if (BYPASS && bus.Regwrite && bus.write_register == bus.read_register_1) begin
      bus.read_busy_1 = 1'b0;
      if (wr_en) bus.read_data_1 = wr_merged;
    end
    if (BYPASS && bus.Regwrite && bus.write_register == bus.read_register_2) begin
      bus.read_busy_2 = 1'b0;
      if (wr_en) bus.read_data_2 = wr_merged;
    end
    if (reset || (ZERO_REG && bus.read_register_1 == '0)) begin
      bus.read_data_1 = '0;
      bus.read_busy_1 = 1'b0;
    end
    if (reset || (ZERO_REG && bus.read_register_2 == '0)) begin
      bus.read_data_2 = '0;
      bus.read_busy_2 = 1'b0;
    end
    bus.busy_count = busy_count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.write_register] <= wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= '0;
      busy_count_q <= '0;
    end else begin
      if (bus.Regwrite) busy[bus.write_register] <= 1'b0;
      if (res_take) busy[bus.reserve_register] <= 1'b1;
      if (set_ev && !clr_ev)
        busy_count_q <= busy_count_q + (ADDR_WIDTH+1)'(1);
      else if (clr_ev && !set_ev)
        busy_count_q <= busy_count_q - (ADDR_WIDTH+1)'(1);
    end
  end
endmodule

// File: tb/tb_gpr_file.sv
// Randomised and directed check of gpr_file (bypass and no-bypass builds)
// against an array-based model of the register file and scoreboard.
module tb_gpr_file;
  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite, rv;
  logic [4:0]  wr, rr, r1, r2;
  logic [31:0] wd;
  logic [3:0]  be;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  always #5 clk = ~clk;

  gpr_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ia ();
  gpr_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ib ();

  assign ia.read_register_1 = r1;  assign ib.read_register_1 = r1;
  assign ia.read_register_2 = r2;  assign ib.read_register_2 = r2;
  assign ia.write_register  = wr;  assign ib.write_register  = wr;
  assign ia.write_data      = wd;  assign ib.write_data      = wd;
  assign ia.write_byteenable = be; assign ib.write_byteenable = be;
  assign ia.Regwrite        = regwrite; assign ib.Regwrite   = regwrite;
  assign ia.reserve_valid   = rv;  assign ib.reserve_valid   = rv;
  assign ia.reserve_register = rr; assign ib.reserve_register = rr;

  gpr_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1), .ZERO_REG(1'b1))
    u_byp (.clk(clk), .reset(rst), .bus(ia));
  gpr_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0), .ZERO_REG(1'b1))
    u_nob (.clk(clk), .reset(rst), .bus(ib));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] en);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (rst || idx == 0) return 32'h0;
    if (byp && regwrite && wr == idx) return lanes(m_regs[idx], wd, be);
    return m_regs[idx];
  endfunction

  function automatic logic exp_rb(input logic [4:0] idx, input bit byp);
    if (rst || idx == 0) return 1'b0;
    if (byp && regwrite && wr == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (rr == 0) return 1'b1;
    return !m_busy[rr] || (regwrite && wr == rr);
  endfunction

  function automatic logic [31:0] exp_count();
    return 32'($countones(m_busy));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = '0;
  endtask

  task automatic model_step();
    logic take;
    take = rv && exp_ready() && rr != 0;
    if (regwrite) begin
      if (wr != 0) m_regs[wr] = lanes(m_regs[wr], wd, be);
      m_busy[wr] = 1'b0;
    end
    if (take) m_busy[rr] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byp_rd1", ia.read_data_1, exp_rd(r1, 1'b1));
      chk("byp_rd2", ia.read_data_2, exp_rd(r2, 1'b1));
      chk("byp_rb1", 32'(ia.read_busy_1), 32'(exp_rb(r1, 1'b1)));
      chk("byp_rb2", 32'(ia.read_busy_2), 32'(exp_rb(r2, 1'b1)));
      chk("byp_ready", 32'(ia.reserve_ready), 32'(exp_ready()));
      chk("byp_count", 32'(ia.busy_count), exp_count());
      chk("nob_rd1", ib.read_data_1, exp_rd(r1, 1'b0));
      chk("nob_rd2", ib.read_data_2, exp_rd(r2, 1'b0));
      chk("nob_rb1", 32'(ib.read_busy_1), 32'(exp_rb(r1, 1'b0)));
      chk("nob_rb2", 32'(ib.read_busy_2), 32'(exp_rb(r2, 1'b0)));
      chk("nob_ready", 32'(ib.reserve_ready), 32'(exp_ready()));
      chk("nob_count", 32'(ib.busy_count), exp_count());
    end
  end

  task automatic apply(input bit rw_, input logic [4:0] wr_, input logic [31:0] wd_,
                       input logic [3:0] be_, input bit rv_, input logic [4:0] rr_,
                       input logic [4:0] r1_, input logic [4:0] r2_);
    regwrite = rw_; wr = wr_; wd = wd_; be = be_;
    rv = rv_; rr = rr_; r1 = r1_; r2 = r2_;
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    regwrite = 0; wr = 0; wd = 0; be = 0; rv = 0; rr = 0; r1 = 0; r2 = 0;
    chk_en = 1'b1;

    // Reset state
    apply(1, 8, 32'hFFFF_FFFF, 4'hF, 1, 3, 8, 3);
    chk("rst_rd1", ia.read_data_1, 32'h0);
    chk("rst_ready", 32'(ia.reserve_ready), 32'h0);
    chk("rst_count", 32'(ia.busy_count), 32'h0);
    tick();
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 8, 3);
    tick();

    // Full-word write and read-back
    apply(1, 8, 32'hDEAD_BEEF, 4'hF, 0, 0, 8, 0);
    chk("byp_same_cycle", ia.read_data_1, 32'hDEAD_BEEF);
    chk("nob_same_cycle", ib.read_data_1, 32'h0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 8, 8);
    chk("r8_next", ib.read_data_1, 32'hDEAD_BEEF);
    chk("r8_busy", 32'(ia.read_busy_1), 32'h0);
    tick();

    // Byte-lane merge
    apply(1, 9, 32'h1122_3344, 4'hF, 0, 0, 9, 9);
    tick();
    apply(1, 9, 32'hAABB_CCDD, 4'b0101, 0, 0, 9, 9);
    chk("r9_byp_merge", ia.read_data_1, 32'h11BB_33DD);
    tick();
    apply(0, 0, 0, 0, 0, 0, 9, 9);
    chk("r9_merge", ib.read_data_2, 32'h11BB_33DD);
    chk("model_r9", m_regs[9], 32'h11BB_33DD);
    tick();

    // Bypass to both ports
    apply(1, 5, 32'h1234_5678, 4'hF, 0, 0, 5, 5);
    chk("r5_byp_p1", ia.read_data_1, 32'h1234_5678);
    chk("r5_byp_p2", ia.read_data_2, 32'h1234_5678);
    chk("r5_nob_old", ib.read_data_2, 32'h0);
    tick();

    // Scoreboard: reserve, observe, retire
    apply(0, 0, 0, 0, 1, 3, 3, 0);
    chk("r3_ready", 32'(ia.reserve_ready), 32'h1);
    tick();
    apply(0, 0, 0, 0, 0, 3, 3, 0);
    chk("r3_busy", 32'(ia.read_busy_1), 32'h1);
    chk("r3_count1", 32'(ia.busy_count), 32'h1);
    chk("r3_not_ready", 32'(ia.reserve_ready), 32'h0);
    tick();
    apply(1, 3, 32'h0000_0033, 4'hF, 0, 3, 3, 0);
    chk("r3_byp_busy0", 32'(ia.read_busy_1), 32'h0);
    chk("r3_nob_busy1", 32'(ib.read_busy_1), 32'h1);
    chk("r3_waw_ready", 32'(ia.reserve_ready), 32'h1);
    tick();
    apply(0, 0, 0, 0, 0, 0, 3, 0);
    chk("r3_count0", 32'(ib.busy_count), 32'h0);
    tick();
    apply(0, 0, 0, 0, 1, 3, 3, 0);
    tick();
    apply(1, 3, 32'h0000_0044, 4'h0, 1, 3, 3, 0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 3, 3);
    chk("r3_set_wins", 32'(ib.read_busy_1), 32'h1);
    chk("r3_count_hold", 32'(ib.busy_count), 32'h1);
    chk("r3_be0_keeps", ib.read_data_2, 32'h0000_0033);
    tick();
    apply(1, 3, 32'h0, 4'h0, 0, 0, 3, 0);
    tick();

    // Register zero
    apply(1, 0, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
    chk("r0_ready", 32'(ia.reserve_ready), 32'h1);
    chk("r0_byp_rd", ia.read_data_1, 32'h0);
    tick();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_rd", ia.read_data_1, 32'h0);
    chk("r0_busy", 32'(ia.read_busy_1), 32'h0);
    chk("r0_count", 32'(ia.busy_count), 32'h0);
    tick();

    // Asynchronous reset between edges
    apply(0, 0, 0, 0, 1, 1, 0, 0); tick();
    apply(0, 0, 0, 0, 1, 2, 0, 0); tick();
    apply(0, 0, 0, 0, 1, 4, 0, 0); tick();
    apply(1, 7, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 5, 7, 1);
    chk("pre_rst_r7", ia.read_data_1, 32'hCAFE_F00D);
    chk("pre_rst_count", 32'(ia.busy_count), 32'h3);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_rd1", ia.read_data_1, 32'h0);
    chk("arst_rb2", 32'(ia.read_busy_2), 32'h0);
    chk("arst_ready", 32'(ia.reserve_ready), 32'h0);
    chk("arst_count", 32'(ia.busy_count), 32'h0);
    tick();
    apply(1, 6, 32'h5555_5555, 4'hF, 1, 6, 7, 6);
    rst = 1'b0;
    tick();
    apply(0, 0, 0, 0, 0, 0, 7, 6);
    chk("post_rst_r7", ia.read_data_1, 32'h0);
    chk("post_rst_r6", ia.read_data_2, 32'h5555_5555);
    tick();

    // Randomised traffic with clustered indices to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a_wr, a_rr, a_r1, a_r2;
      a_wr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a_rr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a_r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a_r2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        model_clear();
      end else begin
        rst = 1'b0;
      end
      apply(1'($urandom_range(0, 2) == 0), a_wr, $urandom, 4'($urandom),
            1'($urandom_range(0, 1)), a_rr, a_r1, a_r2);
      tick();
    end
    rst = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
